// File: rtl/mips_enc_pkg.sv
// mips_enc_pkg
// Shared definitions for the instruction encoder: MIPS primary opcodes and
// function codes, the 3-bit op-select encoding used on the descriptor port,
// the encoder FSM state type and small field-packing helpers.
// No ports. Optional feature macro used by importers: ENC_BRANCH_REL_EN.
package mips_enc_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;

  // Values 6 and 7 are deliberately not enumerated; they are illegal selects.
  typedef enum logic [2:0] {
    SEL_ADD  = 3'd0,
    SEL_ADDI = 3'd1,
    SEL_LW   = 3'd2,
    SEL_SW   = 3'd3,
    SEL_BGTZ = 3'd4,
    SEL_J    = 3'd5
  } op_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } enc_state_e;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_SPECIAL, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if
// Descriptor handshake bundle between a program source and the encoder.
//   in_valid            descriptor valid (source -> encoder)
//   in_ready            encoder can accept (encoder -> source)
//   in_op               op select: 0 add, 1 addi, 2 lw, 3 sw, 4 bgtz, 5 j
//   in_rs/in_rt/in_rd   register fields
//   in_imm              immediate / branch offset or absolute branch address
//   in_target           jump target field
// Modports: master = descriptor source, slave = encoder.
interface instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
    output in_ready
  );

endinterface

// File: rtl/instr_fmt.sv
// instr_fmt
// Combinational formatter: op select + fields + current write address ->
// 32-bit MIPS instruction word, plus an illegal-select flag.
// Optional feature macro: ENC_BRANCH_REL_EN (bgtz imm given as an absolute
// word address, converted here to a PC-relative offset).
// Ports:
//   op        in   3       op select
//   rs/rt/rd  in   5       register fields
//   imm       in   16      immediate
//   target    in   26      jump target
//   addr      in   ADDR_W  word address the instruction will be written to
//   word      out  32      encoded instruction (0 when illegal)
//   illegal   out  1       op select 6/7
module instr_fmt
  import mips_enc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [2:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       word,
  output logic              illegal
);

  logic [15:0] br_imm;

`ifdef ENC_BRANCH_REL_EN
  // Branch target is relative to the following word; wraps as 16-bit two's complement.
  assign br_imm = imm - (16'(addr) + 16'd1);
`else
  logic unused_addr;
  assign unused_addr = ^addr;
  assign br_imm      = imm;
`endif

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      SEL_ADD:  word = pack_r(rs, rt, rd, FUNCT_ADD);
      SEL_ADDI: word = pack_i(OP_ADDI, rs, rt, imm);
      SEL_LW:   word = pack_i(OP_LW, rs, rt, imm);
      SEL_SW:   word = pack_i(OP_SW, rs, rt, imm);
      SEL_BGTZ: word = pack_i(OP_BGTZ, rs, 5'b00000, br_imm);
      SEL_J:    word = {OP_J, target};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Accepts one op descriptor per handshake, encodes it into a MIPS word and
// writes it to instruction memory at sequential word addresses starting at
// BASE_ADDR. Stops accepting after DEPTH = 2**ADDR_W writes until clr/rst.
// Optional feature macro: ENC_BRANCH_REL_EN (see instr_fmt).
// Ports:
//   clk         in   1         clock, all state on posedge
//   rst         in   1         synchronous active-high reset
//   clr         in   1         synchronous restart of address/count/full/err
//   in_if       slave          descriptor handshake (instr_encoder_if)
//   imem_we     out  1         one-cycle write strobe
//   imem_addr   out  ADDR_W    word address of current write
//   imem_wdata  out  32        encoded instruction
//   count       out  ADDR_W+1  words written since reset/clr
//   full        out  1         DEPTH words written
//   err         out  1         sticky illegal-op flag
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | ready for a descriptor
// ST_WRITE | imem_we strobe cycle for the registered word
// ST_FULL  | DEPTH words written; waits for clr or rst
module instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  instr_encoder_if.slave      in_if,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                err
);

  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0]       fmt_word;
  logic              fmt_illegal;
  logic              accept;

  instr_fmt #(
    .ADDR_W (ADDR_W)
  ) u_fmt (
    .op      (in_if.in_op),
    .rs      (in_if.in_rs),
    .rt      (in_if.in_rt),
    .rd      (in_if.in_rd),
    .imm     (in_if.in_imm),
    .target  (in_if.in_target),
    .addr    (addr_q),
    .word    (fmt_word),
    .illegal (fmt_illegal)
  );

  assign in_if.in_ready = (state_q == ST_IDLE) & ~clr & ~rst;
  assign accept         = in_if.in_valid & in_if.in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (fmt_illegal) begin
            err_d = 1'b1;
          end else begin
            wdata_d = fmt_word;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W+1)'(1);
        if (count_d == DEPTH) begin
          full_d  = 1'b1;
          state_d = ST_FULL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FULL: begin
        state_d = ST_FULL;
      end
      default: state_d = ST_IDLE;
    endcase

    // clr overrides everything, including a write that is in its strobe cycle.
    if (clr) begin
      state_d = ST_IDLE;
      addr_d  = BASE;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  // The strobe is gated so a clr or rst arriving in the WRITE cycle drops the write.
  assign imem_we    = (state_q == ST_WRITE) & ~clr & ~rst;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int AW    = 3;
  localparam int BASE  = 6;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  instr_encoder_if enc_if ();

  instr_encoder #(
    .ADDR_W    (AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_if      (enc_if),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_addr;
  int m_count;
  int m_full;
  int m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction word from the MIPS field layout, using plain arithmetic on bit weights.
  function automatic logic [31:0] ref_word(input int op, input int rs, input int rt, input int rd,
                                           input int imm, input int tgt, input int addr);
    longint w;
    int bi;
    bi = imm;
`ifdef ENC_BRANCH_REL_EN
    bi = (imm - (addr + 1)) & 32'h0000_FFFF;
`endif
    case (op)
      0: w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + 32;
      1: w = 64'd8  * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
      2: w = 64'd35 * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
      3: w = 64'd43 * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
      4: w = 64'd7  * 67108864 + longint'(rs) * 2097152 + bi;
      5: w = 64'd2  * 67108864 + tgt;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  task automatic model_restart(input int clear_err);
    m_addr  = BASE;
    m_count = 0;
    m_full  = 0;
    if (clear_err != 0) m_err = 0;
  endtask

  task automatic drive(input int op, input int rs, input int rt, input int rd,
                       input int imm, input int tgt);
    enc_if.in_op     = 3'(op);
    enc_if.in_rs     = 5'(rs);
    enc_if.in_rt     = 5'(rt);
    enc_if.in_rd     = 5'(rd);
    enc_if.in_imm    = 16'(imm);
    enc_if.in_target = 26'(tgt);
  endtask

  // Offers one descriptor, then checks the write cycle and the cycle after it.
  task automatic send(input int op, input int rs, input int rt, input int rd,
                      input int imm, input int tgt);
    int n;
    logic [31:0] exp;
    n = 0;
    while (enc_if.in_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 10) begin
      check_val("ready_timeout", 32'(enc_if.in_ready), 32'd1);
      return;
    end
    drive(op, rs, rt, rd, imm, tgt);
    enc_if.in_valid = 1'b1;
    @(negedge clk);
    enc_if.in_valid = 1'b0;
    #1;
    if (op <= 5) begin
      exp = ref_word(op, rs, rt, rd, imm, tgt, m_addr);
      check_val("we_after_accept", 32'(imem_we), 32'd1);
      check_val("write_addr", 32'(imem_addr), 32'(m_addr));
      check_val("write_data", imem_wdata, exp);
      check_val("ready_low_in_write", 32'(enc_if.in_ready), 32'd0);
      m_addr  = (m_addr + 1) % DEPTH;
      m_count = m_count + 1;
      if (m_count == DEPTH) m_full = 1;
      @(negedge clk);
      #1;
      check_val("we_single_cycle", 32'(imem_we), 32'd0);
      check_val("count", 32'(count), 32'(m_count));
      check_val("full", 32'(full), 32'(m_full));
      check_val("next_addr", 32'(imem_addr), 32'(m_addr));
      check_val("ready_after_write", 32'(enc_if.in_ready), 32'(m_full == 0));
    end else begin
      m_err = 1;
      check_val("illegal_no_we", 32'(imem_we), 32'd0);
      check_val("illegal_err", 32'(err), 32'd1);
      check_val("illegal_addr", 32'(imem_addr), 32'(m_addr));
      check_val("illegal_count", 32'(count), 32'(m_count));
      check_val("illegal_ready", 32'(enc_if.in_ready), 32'd1);
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    #1;
    check_val("ready_low_in_clr", 32'(enc_if.in_ready), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    model_restart(1);
    #1;
    check_val("clr_addr", 32'(imem_addr), 32'(m_addr));
    check_val("clr_count", 32'(count), 32'd0);
    check_val("clr_full", 32'(full), 32'd0);
    check_val("clr_err", 32'(err), 32'd0);
    check_val("clr_ready", 32'(enc_if.in_ready), 32'd1);
  endtask

  task automatic send_random();
    int op;
    op = $urandom_range(0, 7);
    send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 65535), $urandom_range(0, 32'h3FF_FFFF));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    enc_if.in_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    m_err = 0;
    model_restart(1);

    repeat (3) @(negedge clk);
    #1;
    check_val("ready_in_rst", 32'(enc_if.in_ready), 32'd0);
    check_val("we_in_rst", 32'(imem_we), 32'd0);
    rst = 1'b0;
    #1;
    check_val("rst_addr", 32'(imem_addr), 32'(BASE));
    check_val("rst_wdata", imem_wdata, 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_ready", 32'(enc_if.in_ready), 32'd1);

    // directed program, wrapping past the top of a BASE=6 / DEPTH=8 memory
    send(0, 1, 2, 3, 0, 0);
    check_val("add_word", imem_wdata, 32'h0022_1820);
    send(2, 0, 8, 0, 4, 0);
    check_val("lw_word", imem_wdata, 32'h8C08_0004);
    send(5, 0, 0, 0, 0, 'h10);
    check_val("j_word", imem_wdata, 32'h0800_0010);
    check_val("wrap_addr", 32'(imem_addr), 32'd1);
    send(1, 3, 3, 0, 7, 0);
    send(3, 4, 6, 0, 8, 0);
    check_val("bgtz_at_addr3", 32'(imem_addr), 32'd3);
    send(4, 9, 0, 0, 0, 0);
`ifdef ENC_BRANCH_REL_EN
    check_val("bgtz_word", imem_wdata, 32'h1D20_FFFC);
`else
    check_val("bgtz_word", imem_wdata, 32'h1D20_0000);
`endif
    send(6, 1, 1, 1, 1, 1);
    send(1, 4, 5, 0, 'h1234, 0);
    check_val("addi_after_illegal", imem_wdata, 32'h2085_1234);
    check_val("err_sticky", 32'(err), 32'd1);
    send(7, 2, 2, 2, 2, 2);
    do_clr();

    // randomized fills up to full, with a held descriptor while full
    for (int r = 0; r < 3; r++) begin
      for (int it = 0; it < 100 && m_full == 0; it++) send_random();
      check_val("fill_full", 32'(full), 32'd1);
      drive(0, 5, 6, 7, 0, 0);
      enc_if.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        #1;
        check_val("full_no_we", 32'(imem_we), 32'd0);
        check_val("full_no_ready", 32'(enc_if.in_ready), 32'd0);
        check_val("full_count", 32'(count), 32'(DEPTH));
      end
      enc_if.in_valid = 1'b0;
      do_clr();
    end

    // clr in the strobe cycle drops the write
    send(1, 1, 1, 0, 1, 0);
    drive(0, 7, 8, 9, 0, 0);
    enc_if.in_valid = 1'b1;
    @(negedge clk);
    enc_if.in_valid = 1'b0;
    clr = 1'b1;
    #1;
    check_val("clr_drops_we", 32'(imem_we), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    model_restart(1);
    #1;
    check_val("clr_write_count", 32'(count), 32'd0);
    check_val("clr_write_addr", 32'(imem_addr), 32'(BASE));
    check_val("clr_write_ready", 32'(enc_if.in_ready), 32'd1);

    // rst the cycle after accept suppresses the strobe and restores reset values
    send(6, 0, 0, 0, 0, 0);
    send(0, 2, 3, 4, 0, 0);
    drive(5, 0, 0, 0, 0, 'h3F);
    enc_if.in_valid = 1'b1;
    @(negedge clk);
    enc_if.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("rst_drops_we", 32'(imem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_restart(1);
    #1;
    check_val("rst_write_count", 32'(count), 32'd0);
    check_val("rst_write_addr", 32'(imem_addr), 32'(BASE));
    check_val("rst_write_err", 32'(err), 32'd0);
    check_val("rst_write_wdata", imem_wdata, 32'd0);

    // clr and in_valid together: clr wins
    drive(0, 1, 1, 1, 0, 0);
    enc_if.in_valid = 1'b1;
    clr = 1'b1;
    #1;
    check_val("clr_vs_valid_ready", 32'(enc_if.in_ready), 32'd0);
    @(negedge clk);
    enc_if.in_valid = 1'b0;
    clr = 1'b0;
    #1;
    check_val("clr_vs_valid_we", 32'(imem_we), 32'd0);
    check_val("clr_vs_valid_count", 32'(count), 32'd0);

    for (int i = 0; i < 12; i++) send_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
